// File: rtl/scan_pipe_reg_pkg.sv
// Shared definitions for the scan-testable elastic pipeline register.
// The scan chain runs SI -> v[0] -> d0[0..W-1] -> v[1] -> d1[0..W-1] ... -> SO.
// The helpers below give the chain length and the chain position of each bit.
package scan_pipe_reg_pkg;

    // Default value loaded into every data register on reset
    localparam int unsigned DEFAULT_RESET_VAL = 0;

    // Total number of flops in the scan chain
    function automatic int scan_len(input int width, input int depth);
        return depth * (width + 1);
    endfunction

    // Chain position of the valid bit of a stage
    function automatic int scan_v_idx(input int width, input int stage);
        return stage * (width + 1);
    endfunction

    // Chain position of data bit 'bit_idx' of a stage
    function automatic int scan_d_idx(input int width, input int stage, input int bit_idx);
        return stage * (width + 1) + 1 + bit_idx;
    endfunction

endpackage

// File: rtl/scan_pipe_stage.sv
// One pipeline stage: a valid flop plus WIDTH data flops, each with a
// reset / scan-shift / functional-load mux in front of it.
// In scan mode the stage shifts scan_in -> valid -> data[0] -> ... -> data[WIDTH-1].
module scan_pipe_stage
    import scan_pipe_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             se,
    input  logic             scan_in,
    input  logic             load,
    input  logic             adv,
    input  logic [WIDTH-1:0] din,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             scan_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Next state: scan shift when se, otherwise load/advance/hold
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (se) begin
            valid_d   = scan_in;
            data_d[0] = valid_q;
            for (int j = 1; j < WIDTH; j++) begin
                data_d[j] = data_q[j-1];
            end
        end else begin
            if (load) begin
                valid_d = 1'b1;
                data_d  = din;
            end else if (adv) begin
                valid_d = 1'b0;
            end
        end
    end

    // Stage flops; synchronous reset wins over scan and load
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign scan_o  = data_q[WIDTH-1];

endmodule

// File: rtl/scan_pipe_reg.sv
// Elastic, scan-testable pipeline register bank of DEPTH stages.
// Handshake: an item moves across an interface on a rising edge where valid
// and ready are both 1. Here ready is computed combinationally from the stage
// occupancy and out_ready, so a full pipe still accepts an item in the same
// cycle it delivers one. Empty stages are skipped (bubbles collapse).
// While SE=1 the handshake is frozen (in_ready=0, out_valid=0) and every
// edge shifts the scan chain one position.
module scan_pipe_reg
    import scan_pipe_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             SE,
    input  logic             SI,
    output logic             SO,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] D,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QB
);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] load;
    logic [DEPTH-1:0] scan_o;
    logic [WIDTH-1:0] dq [DEPTH];
    logic             room;
    logic             step;

    // Ready chain from the output backwards: a stage advances if the slot ahead is free or freeing
    always_comb begin
        adv  = '0;
        load = '0;
        step = 1'b0;
        room = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            step   = v[i] && room && !SE;
            adv[i] = step;
            room   = !v[i] || step;
        end
        in_ready = !R && !SE && room;
        load[0]  = in_valid && in_ready;
        for (int i = 1; i < DEPTH; i++) begin
            load[i] = adv[i-1];
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             stage_sin;
        logic [WIDTH-1:0] stage_din;

        if (i == 0) begin : g_first
            assign stage_sin = SI;
            assign stage_din = D;
        end else begin : g_rest
            assign stage_sin = scan_o[i-1];
            assign stage_din = dq[i-1];
        end

        scan_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (CLK),
            .rst     (R),
            .se      (SE),
            .scan_in (stage_sin),
            .load    (load[i]),
            .adv     (adv[i]),
            .din     (stage_din),
            .valid_o (v[i]),
            .data_o  (dq[i]),
            .scan_o  (scan_o[i])
        );
    end

    assign SO        = scan_o[DEPTH-1];
    assign out_valid = v[DEPTH-1] && !SE;
    assign Q         = dq[DEPTH-1];
    assign QB        = ~dq[DEPTH-1];

endmodule

// File: tb/tb_scan_pipe_reg.sv
// Self-checking bench for scan_pipe_reg (WIDTH=8, DEPTH=3).
// Reference model: an ordered list of in-flight items with their slot
// positions, the last data written to each slot, and a bit-array view of
// the scan chain; a separate expected queue checks order and data of outputs.
module tb_scan_pipe_reg;

    localparam int               WIDTH = 8;
    localparam int               DEPTH = 3;
    localparam logic [WIDTH-1:0] RST_V = 8'h00;
    localparam int               L     = DEPTH * (WIDTH + 1);

    logic             CLK = 1'b0;
    logic             R, SE, SI, in_valid, out_ready;
    logic [WIDTH-1:0] D;
    logic             SO, in_ready, out_valid;
    logic [WIDTH-1:0] Q, QB;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int               pos;
        logic [WIDTH-1:0] data;
    } item_t;

    item_t            items[$];
    logic [WIDTH-1:0] slot_data[DEPTH];
    logic [WIDTH-1:0] exp_q[$];

    scan_pipe_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RST_V)) dut (
        .CLK(CLK), .R(R), .SE(SE), .SI(SI), .SO(SO),
        .in_valid(in_valid), .in_ready(in_ready), .D(D),
        .out_valid(out_valid), .out_ready(out_ready), .Q(Q), .QB(QB)
    );

    // clock / reset block
    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    // Slot the youngest item would occupy after this edge (DEPTH if pipe empty).
    function automatic int tail_next_pos(input bit ordy);
        int lim = DEPTH;
        int np  = DEPTH;
        for (int k = 0; k < items.size(); k++) begin
            if (k == 0 && items[0].pos == DEPTH - 1) np = ordy ? DEPTH : DEPTH - 1;
            else np = (items[k].pos + 1 < lim - 1) ? items[k].pos + 1 : lim - 1;
            lim = np;
        end
        return np;
    endfunction

    function automatic bit m_in_ready();
        return !R && !SE && (tail_next_pos(out_ready) > 0);
    endfunction

    function automatic bit m_out_valid();
        return !SE && items.size() > 0 && items[0].pos == DEPTH - 1;
    endfunction

    function automatic logic [L-1:0] m_chain();
        logic [L-1:0] ch = '0;
        for (int i = 0; i < DEPTH; i++) begin
            bit occ = 0;
            foreach (items[k]) if (items[k].pos == i) occ = 1;
            ch[i*(WIDTH+1)] = occ;
            for (int j = 0; j < WIDTH; j++) ch[i*(WIDTH+1)+1+j] = slot_data[i][j];
        end
        return ch;
    endfunction

    function automatic bit m_so();
        logic [L-1:0] ch = m_chain();
        return ch[L-1];
    endfunction

    task automatic model_edge();
        item_t nl[$];
        logic [L-1:0] ch;
        int lim, np;
        bit acc;
        if (R) begin
            items.delete();
            for (int i = 0; i < DEPTH; i++) slot_data[i] = RST_V;
        end else if (SE) begin
            ch = m_chain();
            ch = {ch[L-2:0], SI};
            items.delete();
            for (int i = DEPTH - 1; i >= 0; i--) begin
                for (int j = 0; j < WIDTH; j++) slot_data[i][j] = ch[i*(WIDTH+1)+1+j];
                if (ch[i*(WIDTH+1)]) items.push_back('{i, slot_data[i]});
            end
        end else begin
            acc = m_in_ready() && in_valid;
            lim = DEPTH;
            for (int k = 0; k < items.size(); k++) begin
                if (k == 0 && items[0].pos == DEPTH - 1) np = out_ready ? DEPTH : DEPTH - 1;
                else np = (items[k].pos + 1 < lim - 1) ? items[k].pos + 1 : lim - 1;
                if (np < DEPTH) begin
                    if (np != items[k].pos) slot_data[np] = items[k].data;
                    nl.push_back('{np, items[k].data});
                end
                lim = np;
            end
            if (acc) begin
                nl.push_back('{0, D});
                slot_data[0] = D;
            end
            items = nl;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit r, input bit se, input bit si, input bit iv,
                         input logic [WIDTH-1:0] d, input bit ordy);
        R = r; SE = se; SI = si; in_valid = iv; D = d; out_ready = ordy;
        #2;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(1, 0, 0, 0, 8'h00, 0);
        tick();
        tick();
        drive(1, 0, 0, 1, 8'h5A, 1);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_during_r got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (Q !== RST_V) begin errors++; $display("FAIL reset_q got=%h exp=%h", Q, RST_V); end
        checks++; if (QB !== ~RST_V) begin errors++; $display("FAIL reset_qb got=%h exp=%h", QB, ~RST_V); end
        checks++; if (SO !== RST_V[WIDTH-1]) begin errors++; $display("FAIL reset_so got=%b exp=%b", SO, RST_V[WIDTH-1]); end
        tick();
        drive(0, 0, 0, 0, 8'h00, 0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_after got=%b exp=1", in_ready); end
    endtask

    task automatic test_streaming();
        logic [WIDTH-1:0] v;
        for (int c = 0; c < 9; c++) begin
            v = 8'h11 * (c + 1);
            drive(0, 0, 0, c < 3, v, 1);
            if (c < 3) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready c=%0d got=%b exp=1", c, in_ready); end
            end
            checks++;
            if (out_valid !== (c >= 3 && c <= 5)) begin
                errors++; $display("FAIL stream_out_valid c=%0d got=%b exp=%b", c, out_valid, (c >= 3 && c <= 5));
            end
            if (c >= 3 && c <= 5) begin
                checks++; if (Q !== 8'h11 * (c - 2)) begin errors++; $display("FAIL stream_q c=%0d got=%h exp=%h", c, Q, 8'h11 * (c - 2)); end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_stream();
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 0, 1, 8'h11 * (c + 1), 0);
            tick();
        end
        drive(0, 0, 0, 0, 8'h00, 0);
        checks++; if (out_valid !== 1'b1 || Q !== 8'h11) begin errors++; $display("FAIL rstmid_full got=%b/%h exp=1/11", out_valid, Q); end
        drive(1, 0, 0, 0, 8'h00, 0);
        tick();
        drive(0, 0, 0, 0, 8'h00, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
        checks++; if (Q !== 8'h00) begin errors++; $display("FAIL rstmid_q got=%h exp=00", Q); end
        checks++; if (QB !== 8'hFF) begin errors++; $display("FAIL rstmid_qb got=%h exp=ff", QB); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int outs = 0;
        int bad_ready = 0;
        logic [WIDTH-1:0] got;
        exp_q.delete();
        for (int c = 0; c < 6; c++) begin
            drive(0, 0, 0, 1, 8'(idx + 1), 0);
            checks++; if (in_ready !== m_in_ready()) begin errors++; $display("FAIL bp_in_ready c=%0d got=%b exp=%b", c, in_ready, m_in_ready()); end
            if (idx == 3 && in_ready) bad_ready++;
            if (c >= 3) begin
                checks++; if (out_valid !== 1'b1 || Q !== 8'h01) begin errors++; $display("FAIL bp_hold c=%0d got=%b/%h exp=1/01", c, out_valid, Q); end
            end
            if (in_ready) begin exp_q.push_back(D); idx++; end
            tick();
        end
        checks++; if (idx !== 3) begin errors++; $display("FAIL bp_accepted got=%0d exp=3", idx); end
        checks++; if (bad_ready !== 0) begin errors++; $display("FAIL bp_ready_fourth got=%0d exp=0", bad_ready); end
        for (int c = 0; c < 10; c++) begin
            drive(0, 0, 0, idx < 4, 8'(idx + 1), 1);
            if (out_valid) begin
                got = Q; outs++;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL bp_extra_out got=%h exp=none", got); end
                else if (got !== exp_q[0]) begin errors++; $display("FAIL bp_order got=%h exp=%h", got, exp_q[0]); end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (in_valid && in_ready) begin exp_q.push_back(D); idx++; end
            tick();
        end
        checks++; if (outs !== 4 || exp_q.size() !== 0) begin errors++; $display("FAIL bp_count got=%0d left=%0d exp=4 left=0", outs, exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int in_cnt = 0;
        int out_cnt = 0;
        int low = 0;
        for (int c = 0; c < 3 + 20 + 5; c++) begin
            drive(0, 0, 0, c < 23, 8'($urandom_range(0, 255)), 1);
            if (c >= 3 && c < 23 && !in_ready) low++;
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0 || Q !== exp_q[0]) begin
                    errors++; $display("FAIL b2b_data c=%0d got=%h exp=%h", c, Q, (exp_q.size() > 0) ? exp_q[0] : 8'h00);
                end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                if (c >= 3 && c < 23) out_cnt++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(D);
                if (c >= 3) in_cnt++;
            end
            tick();
        end
        checks++; if (low !== 0) begin errors++; $display("FAIL b2b_in_ready_low got=%0d exp=0", low); end
        checks++; if (in_cnt !== 20 || out_cnt !== 20) begin errors++; $display("FAIL b2b_counts got=%0d/%0d exp=20/20", in_cnt, out_cnt); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_drain got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            drive(0, 0, 0, c < 290 && $urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)),
                  $urandom_range(0, 3) != 0);
            checks++; if (in_ready !== m_in_ready()) begin errors++; $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, in_ready, m_in_ready()); end
            checks++; if (out_valid !== m_out_valid()) begin errors++; $display("FAIL rnd_out_valid c=%0d got=%b exp=%b", c, out_valid, m_out_valid()); end
            checks++; if (Q !== slot_data[DEPTH-1] || QB !== ~slot_data[DEPTH-1]) begin
                errors++; $display("FAIL rnd_q c=%0d got=%h/%h exp=%h", c, Q, QB, slot_data[DEPTH-1]);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0 || Q !== exp_q[0]) begin
                    errors++; $display("FAIL rnd_order c=%0d got=%h exp=%h", c, Q, (exp_q.size() > 0) ? exp_q[0] : 8'h00);
                end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (in_valid && in_ready) exp_q.push_back(D);
            tick();
        end
        drive(0, 0, 0, 0, 8'h00, 1);
        for (int c = 0; c < 6; c++) begin
            #0;
            if (out_valid) begin
                if (exp_q.size() > 0 && Q === exp_q[0]) void'(exp_q.pop_front());
            end
            tick();
            drive(0, 0, 0, 0, 8'h00, 1);
        end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL rnd_lost got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_scan();
        logic [L-1:0]     si_bits;
        logic [WIDTH-1:0] exp_d;
        bit               exp_v;
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 0, c < 2, 8'($urandom_range(0, 255)), 0);
            tick();
        end
        for (int k = 0; k < L; k++) begin
            si_bits[k] = 1'($urandom_range(0, 1));
            drive(0, 1, si_bits[k], 1, 8'($urandom_range(0, 255)), 1);
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL scan_hs k=%0d got=%b/%b exp=0/0", k, in_ready, out_valid); end
            checks++; if (SO !== m_so()) begin errors++; $display("FAIL scan_so k=%0d got=%b exp=%b", k, SO, m_so()); end
            tick();
        end
        drive(0, 0, 0, 0, 8'h00, 0);
        exp_v = si_bits[L-1-(DEPTH-1)*(WIDTH+1)];
        for (int j = 0; j < WIDTH; j++) exp_d[j] = si_bits[L-1-((DEPTH-1)*(WIDTH+1)+1+j)];
        checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL scan_load_valid got=%b exp=%b", out_valid, exp_v); end
        checks++; if (Q !== exp_d) begin errors++; $display("FAIL scan_load_q got=%h exp=%h", Q, exp_d); end
        for (int c = 0; c < 6; c++) begin
            drive(0, 0, 0, 0, 8'h00, 1);
            checks++; if (out_valid !== m_out_valid() || Q !== slot_data[DEPTH-1]) begin
                errors++; $display("FAIL scan_resume c=%0d got=%b/%h exp=%b/%h", c, out_valid, Q, m_out_valid(), slot_data[DEPTH-1]);
            end
            tick();
        end
    endtask

    task automatic test_reset_with_scan();
        for (int c = 0; c < 2; c++) begin
            drive(0, 0, 0, 1, 8'hC3 ^ 8'(c), 0);
            tick();
        end
        drive(1, 1, 1, 1, 8'hFF, 1);
        tick();
        drive(0, 0, 0, 0, 8'h00, 0);
        checks++; if (out_valid !== 1'b0 || Q !== RST_V || QB !== ~RST_V) begin
            errors++; $display("FAIL rse_state got=%b/%h/%h exp=0/%h/%h", out_valid, Q, QB, RST_V, ~RST_V);
        end
        checks++; if (SO !== RST_V[WIDTH-1]) begin errors++; $display("FAIL rse_so got=%b exp=%b", SO, RST_V[WIDTH-1]); end
        for (int k = 0; k < L; k++) begin
            drive(0, 1, 0, 0, 8'h00, 0);
            checks++; if (SO !== 1'b0 || SO !== m_so()) begin errors++; $display("FAIL rse_chain k=%0d got=%b exp=0", k, SO); end
            tick();
        end
        drive(0, 0, 0, 0, 8'h00, 0);
        tick();
    endtask

    // ---------------- main sequence and final report ----------------
    initial begin
        R = 1; SE = 0; SI = 0; in_valid = 0; D = '0; out_ready = 0;
        test_reset();
        test_streaming();
        test_reset_mid_stream();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_scan();
        test_reset_with_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
